// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter fed by a single-cycle byte strobe, dropping bytes on a full FIFO.
// Default frame is 8N1; define UART_TX_PARITY_EN for 8E1 (adds an even-parity bit).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in_byte,
  input  logic       in_byte_en,
  output logic       txd,
  output logic       busy,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow
);
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d, overflow_q, overflow_d;
  logic          tick, pop, push, full;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  always_comb begin
    tick       = timer_q == TW'(CLKS_PER_BIT - 1);
    full       = count_q == (AW+1)'(DEPTH);
    // a frame ending on this edge frees a slot, so a strobe into a full FIFO is still accepted
    pop        = count_q != '0 && (state_q == IDLE || (state_q == STOP && tick));
    push       = in_byte_en && (!full || pop);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    overflow_d = overflow_q || (in_byte_en && !push);
    timer_d    = (state_q == IDLE || tick) ? '0 : timer_q + 1'b1;
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    case (state_q)
      IDLE:   state_d = pop ? START : IDLE;
      START:  if (tick) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA:   if (tick) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == 3'd7 ? AFTER_DATA : DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_d = tick ? STOP : PARITY;
`endif
      STOP:   state_d = tick ? (pop ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = mem_q[rd_ptr_q];
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^mem_q[rd_ptr_q] : par_q;
    if (state_d == PARITY) txd_d = par_q;
`endif
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) par_q <= 1'b0;
    else par_q <= par_d;
`endif
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_byte;
  assign txd        = txd_q;
  assign busy       = state_q != IDLE;
  assign fifo_empty = count_q == '0;
  assign fifo_full  = full;
  assign overflow   = overflow_q;
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter on the console output path of the PicoRV32 `system`. It consumes the single-cycle `out_byte`/`out_byte_en` strobe and queues bytes in a small FIFO. It serialises them LSB-first on `txd` at a fixed integer clock divide. The strobe has no backpressure, so a full FIFO drops the byte and records a sticky overflow.

## Interface
- `CLKS_PER_BIT`, default 868: clocks per serial bit (115200 baud at 100 MHz); legal range ≥ 2.
- `FIFO_DEPTH_LOG2`, default 4: FIFO holds 2^FIFO_DEPTH_LOG2 bytes; legal range ≥ 1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_byte`  in  8  byte to transmit (from `out_byte`).
- `in_byte_en`  in  1  one-cycle write strobe (from `out_byte_en`).
- `txd`  out  1  serial line; idle high.
- `busy`  out  1  FSM not in IDLE.
- `fifo_empty`  out  1  FIFO count == 0.
- `fifo_full`  out  1  FIFO count == depth.
- `overflow`  out  1  sticky: a strobe arrived while full.

## Operation
- **FIFO**
  - Circular buffer with registered read/write pointers of FIFO_DEPTH_LOG2 bits, wrapping naturally.
  - Count register is FIFO_DEPTH_LOG2+1 bits.
  - Push on `in_byte_en` && !`fifo_full`.
  - Push on `in_byte_en` && `fifo_full` is ignored: data is dropped and `overflow`←1. Only reset clears `overflow`.
  - Push while full is accepted when a pop occurs on the same edge; count is unchanged.
  - Pop only when registered count ≠ 0, so push and pop never collide on an empty FIFO.
- **FSM states:** IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: if !`fifo_empty`, pop into shift register, zero the bit-timer, go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for CLKS_PER_BIT cycles per bit, shift right, eight bits total, then go to PARITY or STOP.
  - PARITY: `txd`=^byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. At the terminal count:
    - FIFO non-empty: pop and go directly to START, with no idle gap.
    - FIFO empty: go to IDLE.
- **Counters**
  - Bit-timer width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 on each state or bit change.
  - Bit index is 3 bits.
- `txd` is a registered output, never combinational from state.

## Timing
- **Reset values:** `txd`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0. State is IDLE, pointers and count are 0, and stored bytes are lost.
- **Reset mid-frame:** `txd` returns high asynchronously; the partial frame is abandoned and the FIFO is flushed.
- **Latency:** strobe sampled at edge E0 into an empty idle block → START entered and `txd`=0 after edge E1.
- **Frame length:** 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity. Back-to-back frames are contiguous.
- `busy` is high from E1 until the edge that returns the FSM to IDLE.
- `fifo_full`/`fifo_empty` reflect the registered count, valid the cycle after the push/pop edge.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in; frame is 8E1, 11 bit-times.
- Undefined: no PARITY state or logic; DATA goes directly to STOP; frame is 8N1, 10 bit-times.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH_LOG2=2 unless noted.
- **Reset:** hold `resetn`=0 for 5 cycles → `txd`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0. Then release: no activity without a strobe.
- **Single byte 0x55:** one strobe → `txd` low from E1, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop high. `busy` is high for exactly 40 cycles and `fifo_empty`=1 throughout after E1.
- **Back-to-back 0xA5, 0x3C:** two strobes on consecutive cycles → second start bit immediately follows cycle 40 of the first frame, total 80 busy cycles with no idle gap, and the sampled bytes match.
- **Overflow:** 6 strobes on consecutive cycles with bytes 0x01..0x06 → `fifo_full`=1 after the 5th strobe and `overflow`=1 after the 6th. Bytes 0x01..0x05 are transmitted in order and 0x06 never appears. `overflow` stays 1 until reset.
- **Parity (macro defined):** byte 0x07 → parity bit 1 and a 44-cycle frame. Byte 0x03 → parity bit 0.
- **Mid-frame reset:** assert `resetn` low during data bit 3 of 0xFF with 2 bytes queued → `txd`=1 immediately, and FIFO empty after release. No further frames are sent until a new strobe.
